// File: rtl/nibble_fifo.sv
// nibble_fifo: DEPTH x 4-bit synchronous FIFO with sticky overflow/underflow; NIBBLE_FIFO_ALMOST_EN adds almost_full/almost_empty.
// Latency: a write is readable one edge later; dout is registered and valid after the edge that accepts the read.
// Backpressure: writes are dropped when full unless a read is accepted on the same edge; reads are dropped when empty.
module nibble_fifo #(
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 din,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic                       err_clr,
    output logic [3:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
`ifdef NIBBLE_FIFO_ALMOST_EN
    ,
    output logic                       almost_full,
    output logic                       almost_empty
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || DEPTH > 16) begin : g_bad_depth
        $error("nibble_fifo: DEPTH must be a power of two in 4..16");
    end

`ifdef NIBBLE_FIFO_ALMOST_EN
    if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $error("nibble_fifo: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
    end
`endif

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] count_nxt;
    logic          rd_accept;
    logic          wr_accept;

    // Full accepts a write only because the same-edge read frees a slot; empty never falls through.
    assign rd_accept = rd_en && !empty;
    assign wr_accept = wr_en && (!full || rd_accept);

    always_comb begin
        count_nxt = count;
        if (wr_accept && !rd_accept) begin
            count_nxt = count + CW'(1);
        end else if (rd_accept && !wr_accept) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage is left out of reset; stale entries are never readable.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            dout      <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wp <= wp + AW'(1);
            end
            if (rd_accept) begin
                dout <= mem[rp];
                rp   <= rp + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
            // A new error on the same edge as err_clr keeps the bit set.
            if (wr_en && !wr_accept) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && !rd_accept) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

`ifdef NIBBLE_FIFO_ALMOST_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_nibble_fifo.sv
// Scoreboard bench for nibble_fifo: a queue model tracks contents, read data is queued at drive time and popped after the edge.
module tb_nibble_fifo;

    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int AE_LEVEL = 2;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    din;
    logic          wr_en;
    logic          rd_en;
    logic          err_clr;
    logic [3:0]    dout;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
`ifdef NIBBLE_FIFO_ALMOST_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    nibble_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .dout        (dout),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef NIBBLE_FIFO_ALMOST_EN
        ,
        .almost_full (almost_full),
        .almost_empty(almost_empty)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] mq [$];
    logic [3:0] exp_q [$];
    logic [3:0] mdout = 4'h0;
    logic       movf = 1'b0;
    logic       mudf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_status();
        check("count", 32'(count), 32'(mq.size()));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("empty", 32'(empty), 32'(mq.size() == 0));
        check("overflow", 32'(overflow), 32'(movf));
        check("underflow", 32'(underflow), 32'(mudf));
        check("dout", 32'(dout), 32'(mdout));
`ifdef NIBBLE_FIFO_ALMOST_EN
        check("almost_full", 32'(almost_full), 32'(mq.size() >= AF_LEVEL));
        check("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE_LEVEL));
`endif
    endtask

    // One clock: drive, predict, step the edge, then compare 1 time unit later.
    task automatic cycle(input logic w, input logic r, input logic [3:0] d, input logic clr);
        logic rd_acc;
        logic wr_acc;
        wr_en   = w;
        rd_en   = r;
        din     = d;
        err_clr = clr;
        rd_acc  = r && (mq.size() > 0);
        wr_acc  = w && (mq.size() < DEPTH || rd_acc);
        if (rd_acc) exp_q.push_back(mq.pop_front());
        if (wr_acc) mq.push_back(d);
        if (w && !wr_acc) movf = 1'b1;
        else if (clr) movf = 1'b0;
        if (r && !rd_acc) mudf = 1'b1;
        else if (clr) mudf = 1'b0;
        @(posedge clk);
        #1;
        if (rd_acc) mdout = exp_q.pop_front();
        check_status();
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        mdout = 4'h0;
        movf  = 1'b0;
        mudf  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; din = 4'h0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status();
        rst = 1'b0;

        // Underflow from reset, then simultaneous write+read on empty
        cycle(1'b0, 1'b1, 4'h0, 1'b0);
        cycle(1'b1, 1'b1, 4'hA, 1'b0);
        cycle(1'b0, 1'b1, 4'h0, 1'b0);
        // err_clr racing a new underflow: error must win
        cycle(1'b0, 1'b1, 4'h0, 1'b1);
        cycle(1'b0, 1'b0, 4'h0, 1'b1);

        // Fill and drain, with a dropped write while full
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 4'(i), 1'b0);
        cycle(1'b1, 1'b0, 4'hF, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b1);

        // Full with write+read: count pinned at DEPTH, pointers wrap
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 4'(i), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 4'h9, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 4'h0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 9) == 0));

        // Asynchronous reset mid-stream with count=5 and wr_en high
        cycle(1'b0, 1'b0, 4'h0, 1'b1);
        while (mq.size() > 0) cycle(1'b0, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 4'(i + 3), 1'b0);
        cycle(1'b0, 1'b1, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 4'h7, 1'b0);
        cycle(1'b0, 1'b1, 4'h0, 1'b0);
        check("pre_rst_count", 32'(count), 32'd4);
        cycle(1'b1, 1'b0, 4'h5, 1'b0);
        wr_en = 1'b1;
        din   = 4'hC;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_status();
        @(posedge clk);
        #1;
        check_status();
        rst = 1'b0;
        cycle(1'b1, 1'b0, 4'h6, 1'b0);
        cycle(1'b0, 1'b1, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
